// File: rtl/maxpool_relu2.sv
// rtl/maxpool_relu2.sv - 2x2 stride-2 max pooling over three lockstep channels; optional ReLU via MAXPOOL_RELU2_RELU_EN
module maxpool_relu2 #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] conv_in_1,
  input  logic [DATA_BITS-1:0] conv_in_2,
  input  logic [DATA_BITS-1:0] conv_in_3,
  output logic [DATA_BITS-1:0] pool_out_1,
  output logic [DATA_BITS-1:0] pool_out_2,
  output logic [DATA_BITS-1:0] pool_out_3,
  output logic                 valid_out,
  output logic                 frame_done
);

  // Line buffer index is col/2, so the column counter is one bit wider than it.
  localparam int LW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam int CW = LW + 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef logic signed [DATA_BITS-1:0] sample_t;

  function automatic sample_t act(input sample_t x);
`ifdef MAXPOOL_RELU2_RELU_EN
    return (x < 0) ? sample_t'(0) : x;
`else
    return x;
`endif
  endfunction

  // Ties return either operand, which is the same value.
  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  sample_t       r_hold [3];
  sample_t       r_lb   [3][WIDTH/2];
  sample_t       r_pool [3];
  logic          r_valid_out;
  logic          r_frame_done;

  sample_t       w_x [3];
  sample_t       w_p [3];
  sample_t       w_h [3];
  sample_t       w_m [3];
  logic [LW-1:0] w_idx;
  logic          w_col_last;
  logic          w_row_last;

  assign w_idx      = r_col[CW-1:1];
  assign w_col_last = (r_col == CW'(WIDTH - 1));
  assign w_row_last = (r_row == RW'(HEIGHT - 1));

  // Per-channel datapath: activation, horizontal pair max, vertical pair max.
  always_comb begin
    w_x[0] = sample_t'(conv_in_1);
    w_x[1] = sample_t'(conv_in_2);
    w_x[2] = sample_t'(conv_in_3);
    for (int ch = 0; ch < 3; ch++) begin
      w_p[ch] = act(w_x[ch]);
      w_h[ch] = smax(r_hold[ch], w_p[ch]);
      w_m[ch] = smax(r_lb[ch][w_idx], w_h[ch]);
    end
  end

  // Raster counters, hold/line-buffer updates and registered pooled outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        r_hold[ch] <= '0;
        r_pool[ch] <= '0;
        for (int i = 0; i < WIDTH / 2; i++) begin
          r_lb[ch][i] <= '0;
        end
      end
    end else begin
      r_valid_out  <= valid_in & r_col[0] & r_row[0];
      r_frame_done <= valid_in & w_col_last & w_row_last;
      if (valid_in) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        for (int ch = 0; ch < 3; ch++) begin
          if (!r_col[0]) begin
            r_hold[ch] <= w_p[ch];
          end else if (!r_row[0]) begin
            r_lb[ch][w_idx] <= w_h[ch];
          end else begin
            r_pool[ch] <= w_m[ch];
          end
        end
      end
    end
  end

  assign pool_out_1 = r_pool[0];
  assign pool_out_2 = r_pool[1];
  assign pool_out_3 = r_pool[2];
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_relu2.sv
// tb/tb_maxpool_relu2.sv - scoreboard bench for maxpool_relu2 (ramp, stall, peak, random, reset, back-to-back)
module tb_maxpool_relu2;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DB = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DB-1:0] c1 = '0, c2 = '0, c3 = '0;
  logic [DB-1:0] pool_out_1, pool_out_2, pool_out_3;
  logic          valid_out, frame_done;

  maxpool_relu2 #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .conv_in_1  (c1),
    .conv_in_2  (c2),
    .conv_in_3  (c3),
    .pool_out_1 (pool_out_1),
    .pool_out_2 (pool_out_2),
    .pool_out_3 (pool_out_3),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DB-1:0] v1, v2, v3;
    bit            fd;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_fd  = 0;
  logic [DB-1:0] last1 = '0, last2 = '0, last3 = '0;
  int            img[3][H][W];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int act(input int x);
`ifdef MAXPOOL_RELU2_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference 2x2 window max for the window whose bottom-right sample is (r, c).
  function automatic logic [DB-1:0] pexp(input int ch, input int r, input int c);
    int m;
    m = mx(mx(act(img[ch][r-1][c-1]), act(img[ch][r-1][c])),
           mx(act(img[ch][r][c-1]),   act(img[ch][r][c])));
    return DB'(m);
  endfunction

  task automatic build_image(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          0: begin
            img[0][r][c] = r * W + c;
            img[1][r][c] = -5;
            img[2][r][c] = 30 - (r * W + c);
          end
          1: begin
            img[0][r][c] = 0;
            img[1][r][c] = 0;
            img[2][r][c] = (r == 5 && c == 2) ? 700 : 0;
          end
          default: begin
            img[0][r][c] = int'($urandom_range(4095)) - 2048;
            img[1][r][c] = int'($urandom_range(4095)) - 2048;
            img[2][r][c] = int'($urandom_range(4095)) - 2048;
          end
        endcase
      end
  endtask

  task automatic send_frame(input int kind, input bit stall, input int nsamp);
    exp_t e;
    int   r, c;
    build_image(kind);
    for (int idx = 0; idx < nsamp; idx++) begin
      r = idx / W;
      c = idx % W;
      valid_in = 1'b1;
      c1 = DB'(img[0][r][c]);
      c2 = DB'(img[1][r][c]);
      c3 = DB'(img[2][r][c]);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.cyc = cyc + 1;
        e.v1  = pexp(0, r, c);
        e.v2  = pexp(1, r, c);
        e.v3  = pexp(2, r, c);
        e.fd  = (r == H - 1) && (c == W - 1);
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (stall) begin
        valid_in = 1'b0;
        c1 = DB'($urandom);
        c2 = DB'($urandom);
        c3 = DB'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Output monitor: scoreboard pop on valid_out, hold check otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_pool_out_1", pool_out_1, 0);
      chk("rst_pool_out_2", pool_out_2, 0);
      chk("rst_pool_out_3", pool_out_3, 0);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_frame_done", frame_done, 0);
      last1 = '0; last2 = '0; last3 = '0;
    end else if (valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", cyc, mon_e.cyc);
        chk("pool_out_1", pool_out_1, mon_e.v1);
        chk("pool_out_2", pool_out_2, mon_e.v2);
        chk("pool_out_3", pool_out_3, mon_e.v3);
        chk("frame_done", frame_done, mon_e.fd);
        if (frame_done) n_fd++;
        last1 = pool_out_1; last2 = pool_out_2; last3 = pool_out_3;
      end
    end else begin
      chk("frame_done_without_valid", frame_done, 0);
      chk("hold_pool_out_1", pool_out_1, last1);
      chk("hold_pool_out_2", pool_out_2, last2);
      chk("hold_pool_out_3", pool_out_3, last3);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_valid_out", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_pool_out_1", pool_out_1, 0);
    chk("init_valid_out", valid_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(0, 1'b0, W * H);   // continuous ramp
    idle(3);
    send_frame(0, 1'b1, W * H);   // ramp with valid_in toggling
    idle(3);
    send_frame(1, 1'b0, W * H);   // single peak
    idle(2);
    send_frame(2, 1'b0, W * H);   // random signed
    idle(2);

    send_frame(0, 1'b0, 20);      // partial frame, then reset
    valid_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_reset_pool_out_1", pool_out_1, 0);
    chk("mid_reset_queue_empty", sb.size(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(0, 1'b0, W * H);   // first frame after reset
    send_frame(0, 1'b0, W * H);   // back-to-back
    send_frame(0, 1'b0, W * H);
    idle(5);

    chk("queue_drained", sb.size(), 0);
    chk("frame_done_count", n_fd, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
